// File: rtl/ultrasonic_scheduler_pkg.sv
// Shared types and default timing for the round-robin ultrasonic ranging scheduler.
package ultrasonic_scheduler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TRIG,
      ST_WAIT_RISE,
      ST_MEASURE,
      ST_HOLD,
      ST_NEXT
   } state_t;

   localparam logic [15:0] TIMEOUT_CODE      = 16'hFFFF;
   localparam int          DEF_N_SENSORS     = 2;
   localparam int          DEF_TRIG_CYCLES   = 500;
   localparam int          DEF_CYCLES_PER_CM = 2900;
   localparam int          DEF_SLOT_CYCLES   = 5_000_000;
   localparam int          DEF_MAX_CM        = 400;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ultrasonic_scheduler_if.sv
// Result handshake between the ranging scheduler and its display/consumer.
interface ultrasonic_scheduler_if #(
   parameter int IDW = 1
);
   logic [15:0]    dist_cm;
   logic [IDW-1:0] dist_id;
   logic           dist_valid;
   logic           dist_ready;
   logic           timeout;

   modport master (
      output dist_cm, dist_id, dist_valid, timeout,
      input  dist_ready
   );

   modport slave (
      input  dist_cm, dist_id, dist_valid, timeout,
      output dist_ready
   );
endinterface

// File: rtl/ultrasonic_scheduler_echo_timer.sv
// Echo synchroniser, rising-edge detect on the selected sensor and saturating centimetre counter.
module ultrasonic_scheduler_echo_timer #(
   parameter int N_SENSORS     = 2,
   parameter int IDW           = 1,
   parameter int CYCLES_PER_CM = 2900,
   parameter int MAX_CM        = 400
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_SENSORS-1:0] echo,
   input  logic [IDW-1:0]       sel,
   input  logic                 clear,
   input  logic                 count,
   output logic                 echo_s,
   output logic                 echo_rise,
   output logic [15:0]          cm
);
   localparam int SUB_W = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;

   logic [N_SENSORS-1:0] echo_p0;
   logic [N_SENSORS-1:0] echo_p1;
   logic                 echo_s_q;
   logic [SUB_W-1:0]     sub_cnt;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v >= 16'(MAX_CM)) ? 16'(MAX_CM) : v + 16'd1;
   endfunction

   assign echo_s    = echo_p1[sel];
   assign echo_rise = echo_s & ~echo_s_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         echo_p0  <= '0;
         echo_p1  <= '0;
         echo_s_q <= 1'b0;
         sub_cnt  <= '0;
         cm       <= '0;
      end else begin
         // p0 -> p1: two-flop synchroniser for the asynchronous echo pins
         echo_p0  <= echo;
         echo_p1  <= echo_p0;
         echo_s_q <= echo_s;
         if (clear) begin
            sub_cnt <= '0;
            cm      <= '0;
         end else if (count) begin
            if (sub_cnt == SUB_W'(CYCLES_PER_CM - 1)) begin
               sub_cnt <= '0;
               cm      <= sat_inc(cm);
            end else begin
               sub_cnt <= sub_cnt + 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/ultrasonic_scheduler.sv
// Round-robin trigger/measure scheduler for N HC-SR04 rangers sharing one echo timer.
module ultrasonic_scheduler
   import ultrasonic_scheduler_pkg::*;
#(
   parameter int N_SENSORS     = DEF_N_SENSORS,
   parameter int TRIG_CYCLES   = DEF_TRIG_CYCLES,
   parameter int CYCLES_PER_CM = DEF_CYCLES_PER_CM,
   parameter int SLOT_CYCLES   = DEF_SLOT_CYCLES,
   parameter int MAX_CM        = DEF_MAX_CM
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   stop,
   input  logic [N_SENSORS-1:0]   echo,
   output logic [N_SENSORS-1:0]   trigger,
   output logic                   overrun,
   output logic                   busy,
   ultrasonic_scheduler_if.master res
);
   localparam int IDW    = id_width(N_SENSORS);
   localparam int SLOT_W = $clog2(SLOT_CYCLES);

   state_t            state, state_nxt;
   logic [IDW-1:0]    idx;
   logic [SLOT_W-1:0] slot_cnt;
   logic              echo_s, echo_rise;
   logic [15:0]       cm;
   logic              trig_done, slot_end;
   logic              timer_clear, timer_count, publish, pub_timeout;

   assign trig_done = (slot_cnt == SLOT_W'(TRIG_CYCLES - 1));
   // NEXT occupies the final cycle of the slot, so trigger rises are exactly SLOT_CYCLES apart
   assign slot_end  = (slot_cnt == SLOT_W'(SLOT_CYCLES - 2));

   ultrasonic_scheduler_echo_timer #(
      .N_SENSORS     (N_SENSORS),
      .IDW           (IDW),
      .CYCLES_PER_CM (CYCLES_PER_CM),
      .MAX_CM        (MAX_CM)
   ) u_echo_timer (
      .clk       (clk),
      .reset     (reset),
      .echo      (echo),
      .sel       (idx),
      .clear     (timer_clear),
      .count     (timer_count),
      .echo_s    (echo_s),
      .echo_rise (echo_rise),
      .cm        (cm)
   );

   always_ff @(posedge clk) begin
      if (reset || stop) state <= ST_IDLE;
      else               state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:      if (enable) state_nxt = ST_TRIG;
         ST_TRIG:      if (trig_done) state_nxt = ST_WAIT_RISE;
         ST_WAIT_RISE: begin
            if (slot_end)       state_nxt = ST_NEXT;
            else if (echo_rise) state_nxt = ST_MEASURE;
         end
         ST_MEASURE: begin
            if (!echo_s)       state_nxt = slot_end ? ST_NEXT : ST_HOLD;
            else if (slot_end) state_nxt = ST_NEXT;
         end
         ST_HOLD:      if (slot_end) state_nxt = ST_NEXT;
         ST_NEXT:      state_nxt = enable ? ST_TRIG : ST_IDLE;
         default:      state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      trigger     = '0;
      busy        = (state != ST_IDLE);
      timer_clear = 1'b1;
      timer_count = 1'b0;
      publish     = 1'b0;
      pub_timeout = 1'b0;
      case (state)
         ST_TRIG: trigger[idx] = 1'b1;
         ST_WAIT_RISE: begin
            timer_clear = 1'b0;
            timer_count = echo_rise;
            publish     = slot_end;
            pub_timeout = slot_end;
         end
         ST_MEASURE: begin
            timer_clear = 1'b0;
            timer_count = echo_s;
            if (!echo_s) begin
               publish = 1'b1;
            end else if (slot_end) begin
               publish     = 1'b1;
               pub_timeout = 1'b1;
            end
         end
         default: ;
      endcase
      if (stop) timer_clear = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slot_cnt <= '0;
         idx      <= '0;
      end else begin
         if (stop || state == ST_IDLE || state == ST_NEXT) slot_cnt <= '0;
         else                                              slot_cnt <= slot_cnt + 1'b1;
         if (!stop && state == ST_NEXT)
            idx <= (idx == IDW'(N_SENSORS - 1)) ? '0 : idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         res.dist_valid <= 1'b0;
         res.dist_cm    <= '0;
         res.dist_id    <= '0;
         res.timeout    <= 1'b0;
         overrun        <= 1'b0;
      end else if (stop) begin
         res.dist_valid <= 1'b0;
      end else if (publish) begin
         res.dist_cm    <= pub_timeout ? TIMEOUT_CODE : cm;
         res.dist_id    <= idx;
         res.timeout    <= pub_timeout;
         res.dist_valid <= 1'b1;
         if (res.dist_valid && !res.dist_ready) overrun <= 1'b1;
      end else if (res.dist_valid && res.dist_ready) begin
         res.dist_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Directed bench for ultrasonic_scheduler with shortened timing (TRIG=5, CPC=10, SLOT=2000).
module tb_ultrasonic_scheduler;
   localparam int N     = 2;
   localparam int TRIG  = 5;
   localparam int CPC   = 10;
   localparam int SLOT  = 2000;
   localparam int MAXCM = 100;

   logic       clk = 1'b0;
   logic       reset, enable, stop;
   logic [1:0] echo;
   logic [1:0] trigger;
   logic       overrun, busy;
   int         cyc = 0;
   int         n_checks = 0;
   int         n_pass = 0;

   ultrasonic_scheduler_if #(.IDW(1)) res_if();

   ultrasonic_scheduler #(
      .N_SENSORS     (N),
      .TRIG_CYCLES   (TRIG),
      .CYCLES_PER_CM (CPC),
      .SLOT_CYCLES   (SLOT),
      .MAX_CM        (MAXCM)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .stop    (stop),
      .echo    (echo),
      .trigger (trigger),
      .overrun (overrun),
      .busy    (busy),
      .res     (res_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1; enable = 1'b0; stop = 1'b0; echo = '0;
      res_if.dist_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_trig(input logic [1:0] pat, input int max, output int t);
      t = -1;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (trigger === pat) begin
            t = cyc;
            break;
         end
      end
   endtask

   task automatic wait_valid(input int max, output int n);
      n = -1;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (res_if.dist_valid === 1'b1) begin
            n = i + 1;
            break;
         end
      end
   endtask

   task automatic pulse_echo(input int b, input int len);
      echo[b] = 1'b1;
      repeat (len) @(negedge clk);
      echo[b] = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++; if (trigger !== 2'b00) $display("FAIL reset_trigger got=%b exp=00", trigger); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
      n_checks++; if (res_if.dist_valid !== 1'b0 || overrun !== 1'b0 || res_if.timeout !== 1'b0)
         $display("FAIL reset_flags got valid=%b overrun=%b timeout=%b exp=0,0,0",
                  res_if.dist_valid, overrun, res_if.timeout);
      else n_pass++;
      n_checks++; if (res_if.dist_cm !== 16'd0 || res_if.dist_id !== 1'b0)
         $display("FAIL reset_data got cm=%0d id=%0d exp=0,0", res_if.dist_cm, res_if.dist_id);
      else n_pass++;
   endtask

   task automatic test_single_measure();
      int t, hi, n;
      apply_reset();
      enable = 1'b1;
      wait_trig(2'b01, 10, t);
      n_checks++; if (t < 0) $display("FAIL meas_trig_start got=none exp=trigger 01"); else n_pass++;
      hi = 0;
      while (trigger === 2'b01 && hi < 50) begin
         hi++;
         @(negedge clk);
      end
      n_checks++; if (hi != TRIG) $display("FAIL meas_trig_len got=%0d exp=%0d", hi, TRIG); else n_pass++;
      n_checks++; if (trigger !== 2'b00) $display("FAIL meas_trig_fall got=%b exp=00", trigger); else n_pass++;
      repeat (250) @(negedge clk);
      pulse_echo(0, 250);
      wait_valid(10, n);
      n_checks++; if (n != 3) $display("FAIL meas_latency got=%0d exp=3", n); else n_pass++;
      n_checks++; if (res_if.dist_cm !== 16'd25) $display("FAIL meas_cm got=%0d exp=25", res_if.dist_cm); else n_pass++;
      n_checks++; if (res_if.dist_id !== 1'b0 || res_if.timeout !== 1'b0)
         $display("FAIL meas_id_to got id=%0d timeout=%b exp=0,0", res_if.dist_id, res_if.timeout);
      else n_pass++;
   endtask

   task automatic test_round_robin();
      int t0, t1, t2;
      apply_reset();
      res_if.dist_ready = 1'b1;
      enable = 1'b1;
      wait_trig(2'b01, 10, t0);
      wait_trig(2'b10, 2100, t1);
      n_checks++; if (t0 < 0 || t1 < 0 || t1 - t0 != SLOT)
         $display("FAIL rr_slot1 got t0=%0d t1=%0d exp spacing %0d", t0, t1, SLOT);
      else n_pass++;
      wait_trig(2'b01, 2100, t2);
      n_checks++; if (t2 < 0 || t2 - t1 != SLOT)
         $display("FAIL rr_wrap got t1=%0d t2=%0d exp spacing %0d", t1, t2, SLOT);
      else n_pass++;
   endtask

   task automatic test_timeout_saturate();
      int t, t1, n;
      apply_reset();
      res_if.dist_ready = 1'b1;
      enable = 1'b1;
      wait_trig(2'b01, 10, t);
      wait_trig(2'b00, 10, t);
      repeat (20) @(negedge clk);
      pulse_echo(0, 1500);
      wait_valid(10, n);
      n_checks++; if (n < 0 || res_if.dist_cm !== 16'd100 || res_if.timeout !== 1'b0)
         $display("FAIL sat_cm got n=%0d cm=%0d timeout=%b exp cm=100 timeout=0", n, res_if.dist_cm, res_if.timeout);
      else n_pass++;
      wait_trig(2'b10, 1000, t1);
      wait_valid(2100, n);
      n_checks++; if (t1 < 0 || n < 0 || cyc - t1 != SLOT - 1)
         $display("FAIL to_time got t1=%0d delta=%0d exp delta=%0d", t1, cyc - t1, SLOT - 1);
      else n_pass++;
      n_checks++; if (res_if.dist_cm !== 16'hFFFF || res_if.dist_id !== 1'b1 || res_if.timeout !== 1'b1)
         $display("FAIL to_result got cm=%h id=%0d timeout=%b exp ffff,1,1",
                  res_if.dist_cm, res_if.dist_id, res_if.timeout);
      else n_pass++;
   endtask

   task automatic test_overrun();
      int t, n, found;
      apply_reset();
      enable = 1'b1;
      wait_trig(2'b01, 10, t);
      wait_trig(2'b00, 10, t);
      repeat (10) @(negedge clk);
      pulse_echo(0, 100);
      wait_valid(10, n);
      n_checks++; if (n < 0 || res_if.dist_cm !== 16'd10 || overrun !== 1'b0)
         $display("FAIL ovr_first got n=%0d cm=%0d overrun=%b exp cm=10 overrun=0", n, res_if.dist_cm, overrun);
      else n_pass++;
      found = 0;
      for (int i = 0; i < 4100; i++) begin
         @(negedge clk);
         if (res_if.dist_id === 1'b1) begin
            found = 1;
            break;
         end
      end
      n_checks++; if (found == 0 || res_if.dist_cm !== 16'hFFFF || res_if.dist_valid !== 1'b1 || overrun !== 1'b1)
         $display("FAIL ovr_second got found=%0d cm=%h valid=%b overrun=%b exp 1,ffff,1,1",
                  found, res_if.dist_cm, res_if.dist_valid, overrun);
      else n_pass++;
      res_if.dist_ready = 1'b1;
      @(negedge clk);
      n_checks++; if (res_if.dist_valid !== 1'b0 || overrun !== 1'b1)
         $display("FAIL ovr_accept got valid=%b overrun=%b exp 0,1", res_if.dist_valid, overrun);
      else n_pass++;
      res_if.dist_ready = 1'b0;
   endtask

   task automatic test_stop();
      int t, n;
      apply_reset();
      enable = 1'b1;
      wait_trig(2'b01, 10, t);
      wait_trig(2'b00, 10, t);
      repeat (10) @(negedge clk);
      pulse_echo(0, 30);
      wait_valid(10, n);
      n_checks++; if (n < 0 || res_if.dist_cm !== 16'd3)
         $display("FAIL stop_pre got n=%0d cm=%0d exp cm=3", n, res_if.dist_cm);
      else n_pass++;
      wait_trig(2'b10, 2100, t);
      wait_trig(2'b00, 10, t);
      repeat (10) @(negedge clk);
      echo[1] = 1'b1;
      repeat (50) @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      n_checks++; if (busy !== 1'b0 || trigger !== 2'b00 || res_if.dist_valid !== 1'b0)
         $display("FAIL stop_abort got busy=%b trigger=%b valid=%b exp 0,00,0", busy, trigger, res_if.dist_valid);
      else n_pass++;
      stop = 1'b0;
      echo[1] = 1'b0;
      res_if.dist_ready = 1'b1;
      wait_trig(2'b10, 5, t);
      n_checks++; if (t < 0) $display("FAIL stop_resume got trigger=%b exp 10", trigger); else n_pass++;
      wait_trig(2'b00, 10, t);
      repeat (10) @(negedge clk);
      pulse_echo(1, 70);
      wait_valid(10, n);
      n_checks++; if (n < 0 || res_if.dist_cm !== 16'd7 || res_if.dist_id !== 1'b1)
         $display("FAIL stop_remeasure got n=%0d cm=%0d id=%0d exp cm=7 id=1", n, res_if.dist_cm, res_if.dist_id);
      else n_pass++;
   endtask

   task automatic test_enable_drop();
      int t0, t, n, idle_at, stray;
      apply_reset();
      res_if.dist_ready = 1'b1;
      enable = 1'b1;
      wait_trig(2'b01, 10, t0);
      enable = 1'b0;
      wait_trig(2'b00, 10, t);
      repeat (10) @(negedge clk);
      pulse_echo(0, 40);
      wait_valid(10, n);
      n_checks++; if (n < 0 || res_if.dist_cm !== 16'd4 || res_if.dist_id !== 1'b0)
         $display("FAIL en_publish got n=%0d cm=%0d id=%0d exp cm=4 id=0", n, res_if.dist_cm, res_if.dist_id);
      else n_pass++;
      idle_at = -1;
      for (int i = 0; i < 2100; i++) begin
         @(negedge clk);
         if (busy === 1'b0) begin
            idle_at = cyc;
            break;
         end
      end
      n_checks++; if (t0 < 0 || idle_at < 0 || idle_at - t0 != SLOT)
         $display("FAIL en_idle got t0=%0d idle_at=%0d exp delta=%0d", t0, idle_at, SLOT);
      else n_pass++;
      stray = 0;
      repeat (2500) begin
         @(negedge clk);
         if (trigger !== 2'b00 || busy !== 1'b0) stray++;
      end
      n_checks++; if (stray != 0) $display("FAIL en_quiet got active_cycles=%0d exp=0", stray); else n_pass++;
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; stop = 1'b0; echo = '0;
      res_if.dist_ready = 1'b0;
      test_reset();
      test_single_measure();
      test_round_robin();
      test_timeout_saturate();
      test_overrun();
      test_stop();
      test_enable_drop();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
